// File: rtl/rtc_alarm_core.sv
// Time-of-day core: 1 s prescaler, binary h/m/s with set mode, 12/24 h BCD display,
// NUM_ALARM programmable alarms with timed ringing/acknowledge, and day-carry pulse.
module rtc_alarm_core #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned NUM_ALARM = 2,
    parameter int unsigned RING_SEC  = 60
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Set_en,
    input  logic [1:0]           Sel_field,
    input  logic                 Inc,
    input  logic                 Dec,
    input  logic                 Mode12,
    input  logic                 Alm_wr,
    input  logic [2:0]           Alm_idx,
    input  logic [4:0]           Alm_hh,
    input  logic [5:0]           Alm_mm,
    input  logic                 Alm_en_in,
    input  logic                 Alm_ack,
    output logic [7:0]           Hour_bcd,
    output logic [7:0]           Min_bcd,
    output logic [7:0]           Sec_bcd,
    output logic                 Pm,
    output logic                 Tick_1s,
    output logic                 Day_carry,
    output logic [NUM_ALARM-1:0] Ring,
    output logic                 Ring_any
);

    localparam int unsigned   PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [7:0]    RING_LOAD = 8'(RING_SEC);

    typedef struct packed {
        logic       en;
        logic [4:0] hh;
        logic [5:0] mm;
    } alarm_t;

    logic [PW-1:0]        presc_q, presc_d;
    logic [5:0]           sec_q, sec_d;
    logic [5:0]           min_q, min_d;
    logic [4:0]           hour_q, hour_d;
    alarm_t               alarm_q [NUM_ALARM];
    alarm_t               alarm_d [NUM_ALARM];
    logic [NUM_ALARM-1:0] ring_q, ring_d;
    logic [7:0]           ring_cnt_q [NUM_ALARM];
    logic [7:0]           ring_cnt_d [NUM_ALARM];

    logic [7:0]           hour_bcd_q, min_bcd_q, sec_bcd_q;
    logic                 pm_q, tick_q, day_carry_q;

    logic                 tick_c;
    logic                 step_c;
    logic                 roll_c;
    logic                 wr_ok_c;
    logic [NUM_ALARM-1:0] match_c;
    logic [4:0]           disp_hour_c;

    // Binary value 0..59 to two BCD digits.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] tens;
        logic [5:0] ones;
        tens = v / 6'd10;
        ones = v - (tens * 6'd10);
        return {4'(tens), 4'(ones)};
    endfunction

    // Prescaler, carry chain and set-mode field editing.
    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        tick_c  = !Set_en && (presc_q == PRESC_MAX);
        step_c  = Set_en && (Inc != Dec);
        roll_c  = tick_c && (sec_q == 6'd59) && (min_q == 6'd59) && (hour_q == 5'd23);

        if (!Set_en) begin
            presc_d = tick_c ? '0 : presc_q + PW'(1);
        end else if ((Inc || Dec) && (Sel_field == 2'd0)) begin
            presc_d = '0;
        end

        if (tick_c) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d  = 6'd0;
                    hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        if (step_c) begin
            case (Sel_field)
                2'd0: sec_d = Inc ? ((sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1)
                                  : ((sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1);
                2'd1: min_d = Inc ? ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1)
                                  : ((min_q == 6'd0) ? 6'd59 : min_q - 6'd1);
                2'd2: hour_d = Inc ? ((hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1)
                                   : ((hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1);
                default: ;
            endcase
        end
    end

    // Alarm storage, match detection and per-channel ring countdown.
    always_comb begin
        wr_ok_c = Alm_wr && (Alm_hh <= 5'd23) && (Alm_mm <= 6'd59)
                  && (32'(Alm_idx) < NUM_ALARM);
        ring_d  = ring_q;
        match_c = '0;
        for (int i = 0; i < NUM_ALARM; i++) begin
            alarm_d[i]    = alarm_q[i];
            ring_cnt_d[i] = ring_cnt_q[i];

            match_c[i] = tick_c && (sec_q == 6'd59) && alarm_q[i].en
                         && (alarm_q[i].hh == hour_d) && (alarm_q[i].mm == min_d);

            if (tick_c && ring_q[i]) begin
                if (ring_cnt_q[i] <= 8'd1) begin
                    ring_d[i]     = 1'b0;
                    ring_cnt_d[i] = 8'd0;
                end else begin
                    ring_cnt_d[i] = ring_cnt_q[i] - 8'd1;
                end
            end
            if (Alm_ack) begin
                ring_d[i]     = 1'b0;
                ring_cnt_d[i] = 8'd0;
            end
            // A fresh match outranks acknowledge on the same cycle.
            if (match_c[i]) begin
                ring_d[i]     = 1'b1;
                ring_cnt_d[i] = RING_LOAD;
            end
            if (wr_ok_c && (Alm_idx == 3'(i))) begin
                alarm_d[i].en = Alm_en_in;
                alarm_d[i].hh = Alm_hh;
                alarm_d[i].mm = Alm_mm;
                if (!Alm_en_in) begin
                    ring_d[i]     = 1'b0;
                    ring_cnt_d[i] = 8'd0;
                end
            end
        end
    end

    always_comb begin
        if (!Mode12) begin
            disp_hour_c = hour_q;
        end else if (hour_q == 5'd0) begin
            disp_hour_c = 5'd12;
        end else if (hour_q > 5'd12) begin
            disp_hour_c = hour_q - 5'd12;
        end else begin
            disp_hour_c = hour_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            presc_q     <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            ring_q      <= '0;
            hour_bcd_q  <= '0;
            min_bcd_q   <= '0;
            sec_bcd_q   <= '0;
            pm_q        <= 1'b0;
            tick_q      <= 1'b0;
            day_carry_q <= 1'b0;
            for (int i = 0; i < NUM_ALARM; i++) begin
                alarm_q[i]    <= '0;
                ring_cnt_q[i] <= '0;
            end
        end else begin
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            ring_q      <= ring_d;
            hour_bcd_q  <= to_bcd(6'(disp_hour_c));
            min_bcd_q   <= to_bcd(min_q);
            sec_bcd_q   <= to_bcd(sec_q);
            pm_q        <= (hour_q >= 5'd12);
            tick_q      <= tick_c;
            day_carry_q <= roll_c;
            for (int i = 0; i < NUM_ALARM; i++) begin
                alarm_q[i]    <= alarm_d[i];
                ring_cnt_q[i] <= ring_cnt_d[i];
            end
        end
    end

    assign Hour_bcd  = hour_bcd_q;
    assign Min_bcd   = min_bcd_q;
    assign Sec_bcd   = sec_bcd_q;
    assign Pm        = pm_q;
    assign Tick_1s   = tick_q;
    assign Day_carry = day_carry_q;
    assign Ring      = ring_q;
    assign Ring_any  = |ring_q;

endmodule
